// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter between the instruction port (m0) and the
//                LSU port (m1) for a single SRAM port. Decodes the SRAM
//                address window, drives the SRAM controls and returns a
//                registered one-cycle-latency response to the granted master.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned RAM_SIZE   = 32768,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   // Instruction port (read-only)
   input  logic                  m0_req_i,
   input  logic [31:0]           m0_addr_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [31:0]           m0_rdata_o,
   output logic                  m0_err_o,
   // LSU port
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [3:0]            m1_be_i,
   input  logic [31:0]           m1_addr_i,
   input  logic [31:0]           m1_wdata_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [31:0]           m1_rdata_o,
   output logic                  m1_err_o,
   // SRAM port
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   // Round-robin pointer: 0 favours m1, 1 favours m0
   logic rr_q, rr_d;
   // Response registers for the transaction granted in the previous cycle
   logic rsp_valid_q, rsp_valid_d;
   logic rsp_owner_q, rsp_owner_d;
   logic rsp_err_q,   rsp_err_d;
   logic rsp_we_q,    rsp_we_d;

   logic        gnt0;
   logic        gnt1;
   logic        any_gnt;
   logic        contended;
   logic [31:0] sel_addr;
   logic        in_win;
   logic        en;
   logic        unused_addr_lsbs;

   // Combinational grant; contention resolved by the round-robin pointer
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      contended = 1'b0;
      if (!rst) begin
         if (m0_req_i && m1_req_i) begin
            contended = 1'b1;
            gnt0      = rr_q;
            gnt1      = ~rr_q;
         end else begin
            gnt0 = m0_req_i;
            gnt1 = m1_req_i;
         end
      end
   end

   assign any_gnt          = gnt0 | gnt1;
   assign sel_addr         = gnt1 ? m1_addr_i : m0_addr_i;
   assign in_win           = (sel_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
   assign en               = any_gnt & in_win;
   // Word-aligned SRAM addressing: the byte offset within a word is dropped
   assign unused_addr_lsbs = ^sel_addr[1:0];

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign mem_en_o    = en;
   assign mem_addr_o  = en ? {sel_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_we_o    = en & gnt1 & m1_we_i;
   assign mem_be_o    = en ? (gnt1 ? m1_be_i : 4'hF) : 4'h0;
   assign mem_wdata_o = (en & gnt1) ? m1_wdata_i : 32'h0;

   // Next-state: response loaded on every grant, cleared otherwise;
   // pointer flips to the loser only on a contended cycle
   always_comb begin
      rr_d        = rr_q;
      rsp_valid_d = any_gnt;
      rsp_owner_d = gnt1;
      rsp_err_d   = any_gnt & ~in_win;
      rsp_we_d    = gnt1 & m1_we_i;
      if (contended) begin
         rr_d = ~rr_q;
      end
   end

   // State registers; reset drops any outstanding response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
      end else begin
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_we_q    <= rsp_we_d;
      end
   end

   // Response steering: read data only for a successful read
   assign m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
   assign m1_rvalid_o = rsp_valid_q &  rsp_owner_q;
   assign m0_err_o    = m0_rvalid_o & rsp_err_q;
   assign m1_err_o    = m1_rvalid_o & rsp_err_q;
   assign m0_rdata_o  = (m0_rvalid_o & ~rsp_err_q & ~rsp_we_q) ? mem_rdata_i : 32'h0;
   assign m1_rdata_o  = (m1_rvalid_o & ~rsp_err_q & ~rsp_we_q) ? mem_rdata_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with an SRAM model
//                and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int unsigned RAM_SIZE = 32768;
   localparam int unsigned AW       = 15;
   localparam logic [31:0] BASE     = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m1_be_i;
   logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
   logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;

   mem_port_arbiter #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   // SRAM behaviour seen by the DUT: byte-enabled write, one-cycle read
   logic [31:0] sram [0:RAM_SIZE/4-1];
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) sram[mem_addr_o[AW-1:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= sram[mem_addr_o[AW-1:2]];
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [int unsigned];
   int          last_winner;     // master that won the most recent conflict (0 after reset)
   logic        exp_v, exp_owner, exp_err, exp_we;
   logic [31:0] exp_data;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] ref_rd(input int unsigned word);
      return ref_mem.exists(word) ? ref_mem[word] : 32'h0;
   endfunction

   task automatic model_reset();
      last_winner = 0;
      exp_v = 1'b0; exp_owner = 1'b0; exp_err = 1'b0; exp_we = 1'b0; exp_data = 32'h0;
   endtask

   // Compare the response of the previous cycle's grant (called at negedge)
   task automatic check_rsp();
      logic [31:0] d;
      d = (exp_v && !exp_err && !exp_we) ? exp_data : 32'h0;
      chk("m0_rvalid", m0_rvalid_o, exp_v && !exp_owner);
      chk("m1_rvalid", m1_rvalid_o, exp_v &&  exp_owner);
      chk("m0_err",    m0_err_o,    exp_v && !exp_owner && exp_err);
      chk("m1_err",    m1_err_o,    exp_v &&  exp_owner && exp_err);
      chk("m0_rdata",  m0_rdata_o,  (exp_v && !exp_owner) ? d : 32'h0);
      chk("m1_rdata",  m1_rdata_o,  (exp_v &&  exp_owner) ? d : 32'h0);
   endtask

   // One cycle: check last response, drive requests, check grant/SRAM side,
   // record expected response; returns at the next negedge
   task automatic step(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic w1, input logic [3:0] be1, input logic [31:0] a1,
                       input logic [31:0] d1);
      logic        g0, g1, granted, inwin;
      logic [31:0] addr, off, merged;
      int unsigned word;
      check_rsp();
      m0_req_i = r0; m0_addr_i = a0;
      m1_req_i = r1; m1_we_i = w1; m1_be_i = be1; m1_addr_i = a1; m1_wdata_i = d1;
      #1;
      if (r0 && r1) begin
         g1 = (last_winner == 0);
         g0 = !g1;
         last_winner = g1 ? 1 : 0;
      end else begin
         g0 = r0; g1 = r1;
      end
      chk("m0_gnt", m0_gnt_o, g0);
      chk("m1_gnt", m1_gnt_o, g1);
      granted = g0 || g1;
      addr    = g1 ? a1 : a0;
      off     = addr - BASE;
      inwin   = off < RAM_SIZE;
      word    = off / 4;
      chk("mem_en", mem_en_o, granted && inwin);
      if (granted && inwin) begin
         chk("mem_addr", {17'h0, mem_addr_o}, off & 32'hFFFF_FFFC);
         chk("mem_we",   mem_we_o, g1 && w1);
         chk("mem_be",   mem_be_o, g1 ? be1 : 4'hF);
         if (g1 && w1) chk("mem_wdata", mem_wdata_o, d1);
      end else begin
         chk("mem_we_idle", mem_we_o, 1'b0);
         if (!granted) begin
            chk("mem_addr_idle",  {17'h0, mem_addr_o}, 32'h0);
            chk("mem_be_idle",    mem_be_o, 4'h0);
            chk("mem_wdata_idle", mem_wdata_o, 32'h0);
         end
      end
      exp_v     = granted;
      exp_owner = g1;
      exp_err   = !inwin;
      exp_we    = g1 && w1;
      exp_data  = 32'h0;
      if (granted && inwin) begin
         if (g1 && w1) begin
            merged = ref_rd(word);
            for (int b = 0; b < 4; b++) if (be1[b]) merged[8*b +: 8] = d1[8*b +: 8];
            ref_mem[word] = merged;
         end else begin
            exp_data = ref_rd(word);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 32'h2000_0000 + ($urandom & 32'hFFFC);
      if (sel < 5)  return BASE + ($urandom_range(0, 63));
      return BASE + ($urandom % RAM_SIZE);
   endfunction

   initial begin
      for (int i = 0; i < RAM_SIZE/4; i++) sram[i] = 32'h0;
      mem_rdata_i = 32'h0;
      model_reset();
      // Reset with both requests asserted
      rst = 1'b1;
      m0_req_i = 1'b1; m0_addr_i = BASE + 32'h4;
      m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'hF; m1_addr_i = BASE + 32'h8;
      m1_wdata_i = 32'h1234_5678;
      repeat (2) @(negedge clk);
      chk("rst_m0_gnt", m0_gnt_o, 1'b0);
      chk("rst_m1_gnt", m1_gnt_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_be", mem_be_o, 4'h0);
      chk("rst_mem_addr", {17'h0, mem_addr_o}, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_m0_rvalid", m0_rvalid_o, 1'b0);
      chk("rst_m1_rvalid", m1_rvalid_o, 1'b0);
      rst = 1'b0;
      // First conflict after reset goes to m1 (a read here)
      step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 4'hF, BASE + 32'h8, 32'h0);

      // Read after write
      step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1000_0010, 32'hDEADBEEF);
      step(1'b1, 32'h1000_0012, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk("raw_rdata", m0_rdata_o, 32'hDEADBEEF);
      idle();

      // Decode error
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
      chk("dec_err", m1_err_o, 1'b1);
      idle();

      // Partial write over an existing word
      step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF,    BASE + 32'h20, 32'h1122_3344);
      step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0100, BASE + 32'h20, 32'h00AA_0000);
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF,    BASE + 32'h20, 32'h0);
      chk("partial_rdata", m1_rdata_o, 32'h11AA_3344);
      idle();

      // Reset mid-operation: leave the pointer favouring m0 first
      step(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE + 32'h4, 32'h0);
      if (last_winner == 0) step(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE + 32'h4, 32'h0);
      check_rsp();
      m0_req_i = 1'b1; m0_addr_i = BASE + 32'h10; m1_req_i = 1'b0; m1_we_i = 1'b0;
      #1;
      chk("mid_m0_gnt", m0_gnt_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt", m0_gnt_o, 1'b0);
      @(posedge clk); #1;
      chk("mid_rst_rvalid", m0_rvalid_o, 1'b0);
      @(negedge clk);
      chk("mid_rst_rvalid2", m0_rvalid_o, 1'b0);
      rst = 1'b0;
      model_reset();
      // Sustained contention from a freshly reset pointer: m1, m0, m1, ...
      for (int i = 0; i < 6; i++) begin
         step(1'b1, BASE + 32'h10, 1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1) == 1, rand_addr(),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              4'($urandom), rand_addr(), $urandom);
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
